// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage register.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
//
// pipe_state_e : occupancy state of a stage (empty, main held, main+skid held)
// OCC_W        : width of the occupancy report
// occ_of()     : maps a state to its entry count
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int OCC_W = 2;

    function automatic logic [OCC_W-1:0] occ_of(input pipe_state_e st);
        logic [OCC_W-1:0] occ;
        occ = '0;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_FULL:  occ = 2'd1;
            ST_SKID:  occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter used for stall-cycle monitoring.
// Latency: count reflects an increment one clock after i_inc is sampled.
// Backpressure: none; sticks at all-ones instead of wrapping.
//
// Ports:
//   i_clk   : clock, rising edge
//   i_reset : asynchronous reset, active-low, clears the count
//   i_inc   : increment request for this cycle
//   o_cnt   : current count
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid entry.
// Latency: 1 cycle from accept to o_valid.
// Backpressure: SKID=1 absorbs one extra beat and drives a registered o_ready;
//               SKID=0 holds one beat and o_ready follows i_ready combinationally.
//
// Ports:
//   i_clk, i_reset         : clock (rising edge), asynchronous active-low reset
//   i_flush                : drop every held entry (data regs keep stale contents)
//   i_valid/o_ready/i_data : upstream handshake and payload
//   o_valid/i_ready/o_data : downstream handshake and payload (main register)
//   o_occupancy            : held entries, 0..2
//   o_stall_cnt            : saturating count of cycles with o_valid & ~i_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [OCC_W-1:0]  o_occupancy,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_dat;
    logic              skid_load;
    logic              accept;
    logic              deliver;

    assign o_valid     = (state_q != ST_EMPTY);
    assign o_data      = main_q;
    assign o_occupancy = occ_of(state_q);
    assign accept      = i_valid & o_ready;
    assign deliver     = o_valid & i_ready;

    // Skid entry and the ready source are the only structural differences
    // between the two modes.
    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] skid_q;

            always_ff @(posedge i_clk or negedge i_reset) begin
                if (!i_reset) begin
                    skid_q <= '0;
                end else if (skid_load) begin
                    skid_q <= i_data;
                end
            end

            assign skid_dat = skid_q;
            // Registered ready: a function of state only, so no combinational
            // path from i_ready back to the upstream stage.
            assign o_ready  = (state_q != ST_SKID);
        end else begin : g_noskid
            assign skid_dat = '0;
            assign o_ready  = (state_q == ST_EMPTY) | i_ready;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_load = 1'b0;

        if (SKID != 0) begin
            case (state_q)
                ST_EMPTY: begin
                    if (i_valid) begin
                        main_d  = i_data;
                        state_d = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (i_ready) begin
                        if (i_valid) begin
                            main_d = i_data;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else if (i_valid) begin
                        // Downstream stalled while upstream still had a beat in
                        // flight: park it in the skid entry.
                        skid_load = 1'b1;
                        state_d   = ST_SKID;
                    end
                end
                ST_SKID: begin
                    if (i_ready) begin
                        main_d  = skid_dat;
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end else begin
            if (accept) begin
                main_d  = i_data;
                state_d = ST_FULL;
            end else if (deliver) begin
                state_d = ST_EMPTY;
            end else if (state_q == ST_SKID) begin
                state_d = ST_EMPTY;
            end
        end

        // Flush discards both the accept and the deliver of this cycle; the
        // data registers are left untouched since they are invalid afterwards.
        if (i_flush) begin
            state_d   = ST_EMPTY;
            main_d    = main_q;
            skid_load = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
        end
    end

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (o_valid & ~i_ready),
        .o_cnt   (o_stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

    localparam int N = 3;   // dut0: SKID=1, dut1: SKID=0, dut2: SKID=1 with 4-bit counter

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        vld;
    logic        rdy;
    logic [31:0] din;

    logic        ov  [N];
    logic        ordy[N];
    logic [31:0] od  [N];
    logic [1:0]  oc  [N];
    logic [15:0] sc  [N];
    logic [15:0] sc_a;
    logic [15:0] sc_b;
    logic [3:0]  sc4;

    assign sc[0] = sc_a;
    assign sc[1] = sc_b;
    assign sc[2] = {12'd0, sc4};

    int total = 0;
    int bad   = 0;

    // Reference model: each stage is a bounded FIFO of payloads plus a stall count.
    logic [31:0] exp_q [N][$];
    int          stall_m [N];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(16)) dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush), .i_valid(vld), .o_ready(ordy[0]),
        .i_data(din), .o_valid(ov[0]), .i_ready(rdy), .o_data(od[0]),
        .o_occupancy(oc[0]), .o_stall_cnt(sc_a));

    pipe_stage_reg #(.DATA_W(32), .SKID(0), .CNT_W(16)) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush), .i_valid(vld), .o_ready(ordy[1]),
        .i_data(din), .o_valid(ov[1]), .i_ready(rdy), .o_data(od[1]),
        .o_occupancy(oc[1]), .o_stall_cnt(sc_b));

    pipe_stage_reg #(.DATA_W(32), .SKID(1), .CNT_W(4)) dut2 (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush), .i_valid(vld), .o_ready(ordy[2]),
        .i_data(din), .o_valid(ov[2]), .i_ready(rdy), .o_data(od[2]),
        .o_occupancy(oc[2]), .o_stall_cnt(sc4));

    function automatic bit has_skid(input int i);
        return (i != 1);
    endfunction

    function automatic int cmax(input int i);
        return (i == 2) ? 15 : 65535;
    endfunction

    function automatic void chk(input string nm, input int idx,
                                input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, idx, act, exp, $time);
        end
    endfunction

    // One clock of stimulus. Outputs are checked against the model a little
    // after the inputs settle, then the model advances for the coming edge.
    task automatic step(input logic v, input logic [31:0] d, input logic r, input logic f);
        int occ;
        bit mr;
        @(negedge clk);
        if (!rst_n) rst_n = 1'b1;
        vld = v; din = d; rdy = r; flush = f;
        #1;
        for (int i = 0; i < N; i++) begin
            occ = exp_q[i].size();
            mr  = has_skid(i) ? (occ < 2) : ((occ == 0) || r);
            chk("occupancy", i, 32'(oc[i]), 32'(occ));
            chk("o_valid", i, 32'(ov[i]), 32'(occ > 0));
            chk("o_ready", i, 32'(ordy[i]), 32'(mr));
            chk("stall_cnt", i, 32'(sc[i]), 32'(stall_m[i]));
            if (occ > 0 && !r && stall_m[i] < cmax(i)) stall_m[i]++;
            if (f) exp_q[i].delete();
            else if (v && mr) exp_q[i].push_back(d);
        end
    endtask

    // Asynchronous reset asserted mid-cycle; released by the next step().
    task automatic do_reset(input int cycles);
        @(negedge clk);
        #2;
        vld = 1'b1; din = 32'hDEADBEEF; rdy = 1'b1; flush = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_data", i, od[i], 32'd0);
            chk("rst_occ", i, 32'(oc[i]), 32'd0);
            chk("rst_stall", i, 32'(sc[i]), 32'd0);
            exp_q[i].delete();
            stall_m[i] = 0;
        end
        repeat (cycles) @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk("rst_hold_valid", i, 32'(ov[i]), 32'd0);
            chk("rst_hold_data", i, od[i], 32'd0);
            chk("rst_ready", i, 32'(ordy[i]), 32'd1);
        end
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents a delivered beat.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && !flush) begin
                for (int i = 0; i < N; i++) begin
                    if (ov[i] && rdy) begin
                        if (exp_q[i].size() == 0) begin
                            chk("unexpected_beat", i, od[i], 32'hFFFF_FFFF ^ od[i]);
                        end else begin
                            chk("o_data", i, od[i], exp_q[i].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1; flush = 1'b0; vld = 1'b0; rdy = 1'b1; din = '0;
        for (int i = 0; i < N; i++) stall_m[i] = 0;

        // Reset and single transfer.
        do_reset(3);
        step(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Back-to-back streaming.
        for (int k = 1; k <= 100; k++) step(1'b1, 32'(k), 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Skid fill: A held, stall, push B, C ignored, then release.
        step(1'b1, 32'hA, 1'b1, 1'b0);
        step(1'b1, 32'hB, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b1, 32'hC, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Flush with occupancy 2 and simultaneous accept/deliver.
        step(1'b1, 32'h11, 1'b1, 1'b0);
        step(1'b1, 32'h22, 1'b0, 1'b0);
        step(1'b1, 32'h33, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Counter saturation on the 4-bit instance.
        step(1'b1, 32'h55, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int k = 0; k < 1500; k++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 31) == 0));
        end

        // Reset in the middle of traffic, then more random traffic.
        step(1'b1, 32'h77, 1'b0, 1'b0);
        do_reset(2);
        for (int k = 0; k < 500; k++) begin
            step(1'($urandom_range(0, 1) != 0), $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end

        // Drain and confirm nothing was left undelivered.
        for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) chk("drained", i, 32'(exp_q[i].size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
